// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package instr_fetch_pkg;

  localparam int unsigned INSTR_WIDTH  = 32;
  localparam int unsigned DEF_PC_WIDTH = 32;

  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    S_REQ  = 1'b0,
    S_WAIT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory req/gnt/rvalid port; the fetch stage is the master.
interface instr_fetch_if
  import instr_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_PC_WIDTH
) ();

  logic                   req;
  logic [ADDR_W-1:0]      addr;
  logic                   gnt;
  logic                   rvalid;
  logic [INSTR_WIDTH-1:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);

endinterface

// File: rtl/fetch_skid_buf.sv
// IF/ID output register backed by one skid entry, so a stalled consumer
// never loses a fetched instruction that was already in flight.
module fetch_skid_buf
  import instr_fetch_pkg::*;
#(
  parameter int unsigned         PC_WIDTH = DEF_PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   stall,
  input  logic                   in_valid,
  input  logic [PC_WIDTH-1:0]    in_pc,
  input  logic [INSTR_WIDTH-1:0] in_instr,
  output logic                   out_valid,
  output logic [PC_WIDTH-1:0]    out_pc,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic                   skid_valid
);

  logic [PC_WIDTH-1:0]    skid_pc;
  logic [INSTR_WIDTH-1:0] skid_instr;
  logic                   consume;

  assign consume = out_valid && !stall;

  // The fetch FSM never issues while the skid is full, so in_valid and
  // skid_valid are never both set; the skid always drains first.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_pc     <= RESET_PC;
      out_instr  <= NOP_INSTR;
      skid_valid <= 1'b0;
      skid_pc    <= RESET_PC;
      skid_instr <= NOP_INSTR;
    end else if (flush) begin
      out_valid  <= 1'b0;
      out_instr  <= NOP_INSTR;
      skid_valid <= 1'b0;
    end else if (consume) begin
      if (skid_valid) begin
        out_pc     <= skid_pc;
        out_instr  <= skid_instr;
        skid_valid <= 1'b0;
      end else if (in_valid) begin
        out_pc    <= in_pc;
        out_instr <= in_instr;
      end else begin
        out_valid <= 1'b0;
        out_instr <= NOP_INSTR;
      end
    end else if (in_valid) begin
      if (!out_valid) begin
        out_valid <= 1'b1;
        out_pc    <= in_pc;
        out_instr <= in_instr;
      end else begin
        skid_valid <= 1'b1;
        skid_pc    <= in_pc;
        skid_instr <= in_instr;
      end
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// IF stage: owns the PC, keeps at most one imem request outstanding,
// squashes responses made stale by a redirect and feeds IF/ID via a skid buffer.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned         PC_WIDTH = DEF_PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_stall,
  input  logic                   i_redirect,
  input  logic [PC_WIDTH-1:0]    i_redirect_pc,
  instr_fetch_if.master          imem,
  output logic                   o_valid,
  output logic [INSTR_WIDTH-1:0] o_instruction,
  output logic [PC_WIDTH-1:0]    o_pc
);

  fetch_state_t        state;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] req_pc;
  logic [PC_WIDTH-1:0] redirect_target;
  logic                squash;
  logic                skid_valid;
  logic                req_fire;
  logic                deliver;

  assign redirect_target = i_redirect_pc & ~PC_WIDTH'(3);

  // i_stall only reaches the request through the registered skid_valid.
  assign imem.req  = !rst && (state == S_REQ) && !skid_valid && !i_redirect;
  assign imem.addr = pc;
  assign req_fire  = imem.req && imem.gnt;
  assign deliver   = (state == S_WAIT) && imem.rvalid && !squash && !i_redirect;

  // PC, request tracking and squash of the response orphaned by a redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_REQ;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
      squash <= 1'b0;
    end else if (i_redirect) begin
      pc <= redirect_target;
      if ((state == S_WAIT) && !imem.rvalid) begin
        squash <= 1'b1;
      end else begin
        state  <= S_REQ;
        squash <= 1'b0;
      end
    end else begin
      unique case (state)
        S_REQ: begin
          if (req_fire) begin
            req_pc <= pc;
            pc     <= pc + PC_WIDTH'(4);
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem.rvalid) begin
            state  <= S_REQ;
            squash <= 1'b0;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

  fetch_skid_buf #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .flush      (i_redirect),
    .stall      (i_stall),
    .in_valid   (deliver),
    .in_pc      (req_pc),
    .in_instr   (imem.rdata),
    .out_valid  (o_valid),
    .out_pc     (o_pc),
    .out_instr  (o_instruction),
    .skid_valid (skid_valid)
  );

endmodule
